ibuf_ctrl: RTL

IBUF_CTRL -- requirements
Module: ibuf_ctrl

---
 rtl/ibuf_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ibuf_ctrl.sv
// Instruction-buffer front end: two fetch lanes with round-robin arbitration into an external FIFO,
// a registered decode-side output stage, timed FIFO flush on redirect, and a saturating stall counter.
module ibuf_ctrl #(
  parameter int DATA_W    = 104,
  parameter int CNT_W     = 16,
  parameter int FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_req,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              fifo_push_en,
  output logic [DATA_W-1:0] fifo_push_data,
  output logic              fifo_pop_en,
  input  logic [DATA_W-1:0] fifo_pop_data,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  output logic              fifo_flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int FCNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYC - 1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic [FCNT_W-1:0]   fcnt_r, fcnt_s;
  logic                rr_ptr_r, rr_ptr_s;
  logic                out_valid_r;
  logic [DATA_W-1:0]   out_data_r;
  logic [CNT_W-1:0]    stall_cnt_r;
  logic                active_s, grant0_s, grant1_s, pop_s;

  // Arbitration, FIFO strobes and handshakes; everything is gated off while in reset
  always_comb begin
    active_s = rst & (state_r == RUN) & ~flush_req;
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (active_s & ~fifo_full) begin
      if (in0_valid & (~in1_valid | ~rr_ptr_r)) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = in1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
    pop_s          = active_s & ~fifo_empty & (~out_valid_r | out_ready);
    in0_ready      = grant0_s;
    in1_ready      = grant1_s;
    fifo_push_en   = grant0_s | grant1_s;
    fifo_push_data = grant1_s ? in1_data : in0_data;
    fifo_pop_en    = pop_s;
    fifo_flush     = rst & (state_r == FLUSH);
  end

  // Next state, flush counter and round-robin pointer
  always_comb begin
    state_s  = state_r;
    fcnt_s   = fcnt_r;
    rr_ptr_s = rr_ptr_r;
    case (state_r)
      RUN: begin
        if (flush_req) begin
          state_s = FLUSH;
          fcnt_s  = FCNT_LOAD;
        end else begin
          state_s = RUN;
        end
      end
      FLUSH: begin
        if (flush_req) begin
          fcnt_s = FCNT_LOAD;
        end else if (fcnt_r == {FCNT_W{1'b0}}) begin
          state_s = RUN;
        end else begin
          fcnt_s = fcnt_r - FCNT_W'(1);
        end
      end
      default: begin
        state_s = RUN;
        fcnt_s  = {FCNT_W{1'b0}};
      end
    endcase
    if (grant0_s) begin
      rr_ptr_s = 1'b1;
    end else if (grant1_s) begin
      rr_ptr_s = 1'b0;
    end else begin
      rr_ptr_s = rr_ptr_r;
    end
  end

  // State, output register and stall counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= RUN;
      fcnt_r      <= {FCNT_W{1'b0}};
      rr_ptr_r    <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_s;
      fcnt_r   <= fcnt_s;
      rr_ptr_r <= rr_ptr_s;
      // A redirect kills whatever decode has not yet taken
      if (flush_req) begin
        out_valid_r <= 1'b0;
      end else if (pop_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= fifo_pop_data;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
      if ((state_r == RUN) && (in0_valid | in1_valid) && fifo_full &&
          (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign stall_cnt = stall_cnt_r;

endmodule
